// File: rtl/jk_excitation_driver.sv
// Purpose : drives a bank of external JK flip-flops to a requested Q vector using the JK
//           excitation table, then checks the fed-back Q against the target.
// Latency : done pulses SETTLE_CYCLES+2 cycles after accept; one target per SETTLE_CYCLES+3 cycles.
// Backpr. : tgt_ready is high only in IDLE; a request arriving elsewhere is held by the producer.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   tgt_valid/ready/data  target request handshake and requested next Q
//   dc_mode               don't-care resolution (0 -> 0, 1 -> 1), sampled at accept
//   j, k                  excitation to the flip-flop bank (pulsed for one cycle)
//   q_fb                  Q fed back from the bank
//   done, mismatch,       one-cycle completion pulse and per-transaction result
//   err_bits
//   txn_count, err_count  saturating completed / mismatched transaction counters
module jk_excitation_driver #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             dc_mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] err_bits,
  output logic [15:0]      txn_count,
  output logic [15:0]      err_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] pres_q, pres_d;
  logic             dc_q, dc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] err_bits_q, err_bits_d;
  logic [15:0]      txn_q, txn_d;
  logic [15:0]      errc_q, errc_d;

  logic [WIDTH-1:0] dc_vec;
  logic [WIDTH-1:0] diff;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    pres_d     = pres_q;
    dc_d       = dc_q;
    cnt_d      = cnt_q;
    mismatch_d = mismatch_q;
    err_bits_d = err_bits_q;
    txn_d      = txn_q;
    errc_d     = errc_q;
    diff       = q_fb ^ tgt_q;

    case (state_q)
      IDLE: begin
        // ready_q gates accept so nothing is taken in the cycle right after reset
        if (tgt_valid && ready_q) begin
          tgt_d   = tgt_data;
          pres_d  = q_fb;
          dc_d    = dc_mode;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d   = CW'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          err_bits_d = diff;
          mismatch_d = |diff;
          // counters step on entry to CHECK so they are current while done is high
          txn_d      = (txn_q == 16'hFFFF) ? txn_q : txn_q + 16'd1;
          if (|diff) begin
            errc_d = (errc_q == 16'hFFFF) ? errc_q : errc_q + 16'd1;
          end
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Excitation from the captured present/target: a don't-care takes dc_mode.
    dc_vec = {WIDTH{dc_d}};
    if (state_d == DRIVE) begin
      j_d = (~pres_d & tgt_d) | (pres_d & dc_vec);
      k_d = (pres_d & ~tgt_d) | (~pres_d & dc_vec);
    end else begin
      j_d = '0;
      k_d = '0;
    end
    ready_d = (state_d == IDLE);
    done_d  = (state_d == CHECK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      pres_q     <= '0;
      dc_q       <= 1'b0;
      cnt_q      <= '0;
      j_q        <= '0;
      k_q        <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_bits_q <= '0;
      txn_q      <= '0;
      errc_q     <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      pres_q     <= pres_d;
      dc_q       <= dc_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      k_q        <= k_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
      err_bits_q <= err_bits_d;
      txn_q      <= txn_d;
      errc_q     <= errc_d;
    end
  end

  assign tgt_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign err_bits  = err_bits_q;
  assign txn_count = txn_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Purpose : self-checking bench for jk_excitation_driver with a behavioural JK bank.
// Latency : checks done at accept+3 cycles and ready at accept+4 (SETTLE_CYCLES=1).
// Backpr. : producer holds tgt_valid; bench verifies nothing is taken outside IDLE.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [3:0] tgt_data;
  logic       dc_mode;
  logic [3:0] j, k, q_fb;
  logic       done, mismatch;
  logic [3:0] err_bits;
  logic [15:0] txn_count, err_count;

  int n_chk  = 0;
  int n_pass = 0;

  // behavioural JK bank; stuck bits are held at 0
  logic       bank_rst;
  logic [3:0] bank_q;
  logic [3:0] stuck;

  // reference model state
  logic [3:0] m_q;
  int         m_txn, m_err;

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_data(tgt_data), .dc_mode(dc_mode), .j(j), .k(k), .q_fb(q_fb),
    .done(done), .mismatch(mismatch), .err_bits(err_bits),
    .txn_count(txn_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bank_rst) bank_q <= 4'b0000;
    else          bank_q <= ((j & ~bank_q) | (~k & bank_q)) & ~stuck;
  end
  assign q_fb = bank_q;

  // Excitation table, one bit at a time
  function automatic void excite(input logic [3:0] q, input logic [3:0] t, input logic dc,
                                 output logic [3:0] ej, output logic [3:0] ek);
    for (int i = 0; i < 4; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin ej[i] = 1'b0; ek[i] = dc;   end
        2'b01:   begin ej[i] = 1'b1; ek[i] = dc;   end
        2'b10:   begin ej[i] = dc;   ek[i] = 1'b1; end
        default: begin ej[i] = dc;   ek[i] = 1'b0; end
      endcase
    end
  endfunction

  // One transaction starting at a negedge with the block idle.
  // hold=1 keeps tgt_valid high and presents nxt from cycle 1 on.
  task automatic run_txn(input logic [3:0] t, input logic dc, input bit hold, input logic [3:0] nxt);
    logic [3:0] ej, ek, eq, eb;
    excite(m_q, t, dc, ej, ek);
    eq = t & ~stuck;
    eb = eq ^ t;
    n_chk++; if (tgt_ready !== 1'b1) $display("FAIL ready_idle: got %b want 1", tgt_ready); else n_pass++;
    tgt_valid = 1'b1; tgt_data = t; dc_mode = dc;
    @(posedge clk);
    @(negedge clk);                                   // cycle 1: DRIVE
    n_chk++; if (j !== ej) $display("FAIL drive_j: tgt=%b got %b want %b", t, j, ej); else n_pass++;
    n_chk++; if (k !== ek) $display("FAIL drive_k: tgt=%b got %b want %b", t, k, ek); else n_pass++;
    n_chk++; if (tgt_ready !== 1'b0) $display("FAIL ready_drive: got %b want 0", tgt_ready); else n_pass++;
    if (hold) begin tgt_data = nxt; dc_mode = ~dc; end
    else      tgt_valid = 1'b0;
    @(negedge clk);                                   // cycle 2: SETTLE
    n_chk++; if ({j, k, done} !== 9'b0) $display("FAIL settle_quiet: got j=%b k=%b done=%b want 0", j, k, done); else n_pass++;
    n_chk++; if (tgt_ready !== 1'b0) $display("FAIL ready_settle: got %b want 0", tgt_ready); else n_pass++;
    m_txn = (m_txn == 65535) ? m_txn : m_txn + 1;
    if (eb != 4'b0) m_err = (m_err == 65535) ? m_err : m_err + 1;
    @(negedge clk);                                   // cycle 3: CHECK
    n_chk++; if (done !== 1'b1) $display("FAIL done_pulse: got %b want 1", done); else n_pass++;
    n_chk++; if (mismatch !== (eb != 4'b0)) $display("FAIL mismatch: got %b want %b", mismatch, (eb != 4'b0)); else n_pass++;
    n_chk++; if (err_bits !== eb) $display("FAIL err_bits: got %b want %b", err_bits, eb); else n_pass++;
    n_chk++; if (txn_count !== 16'(m_txn)) $display("FAIL txn_count: got %0d want %0d", txn_count, m_txn); else n_pass++;
    n_chk++; if (err_count !== 16'(m_err)) $display("FAIL err_count: got %0d want %0d", err_count, m_err); else n_pass++;
    n_chk++; if (q_fb !== eq) $display("FAIL bank_q: got %b want %b", q_fb, eq); else n_pass++;
    n_chk++; if (tgt_ready !== 1'b0) $display("FAIL ready_check: got %b want 0", tgt_ready); else n_pass++;
    @(negedge clk);                                   // cycle 4: IDLE again
    n_chk++; if (done !== 1'b0) $display("FAIL done_low: got %b want 0", done); else n_pass++;
    n_chk++; if (tgt_ready !== 1'b1) $display("FAIL ready_after: got %b want 1", tgt_ready); else n_pass++;
    m_q = eq;
    if (hold) dc_mode = dc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bank_rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0; dc_mode = 1'b0; stuck = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (tgt_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", tgt_ready); else n_pass++;
    n_chk++; if ({j, k, done, mismatch, err_bits} !== 14'b0) $display("FAIL rst_outputs: got j=%b k=%b done=%b mm=%b eb=%b want 0", j, k, done, mismatch, err_bits); else n_pass++;
    n_chk++; if ({txn_count, err_count} !== 32'b0) $display("FAIL rst_counters: got %0d/%0d want 0/0", txn_count, err_count); else n_pass++;
    rst_n = 1'b1; bank_rst = 1'b0;
    @(negedge clk);
    n_chk++; if (tgt_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", tgt_ready); else n_pass++;
    m_q = 4'b0000; m_txn = 0; m_err = 0;
  endtask

  task automatic test_basic();
    run_txn(4'b1010, 1'b0, 1'b0, 4'b0000);            // j=1010 k=0000
  endtask

  task automatic test_dc_one();
    run_txn(4'b0110, 1'b1, 1'b0, 4'b0000);            // j=1110 k=1101
  endtask

  task automatic test_stuck_bit();
    run_txn(4'b0000, 1'b1, 1'b0, 4'b0000);
    stuck = 4'b0001;
    run_txn(4'b0001, 1'b0, 1'b0, 4'b0000);            // mismatch, err_bits=0001
    stuck = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic [3:0] ej, ek;
    excite(m_q, 4'b1001, 1'b0, ej, ek);
    tgt_valid = 1'b1; tgt_data = 4'b1001; dc_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);                                   // DRIVE cycle
    n_chk++; if (j !== ej) $display("FAIL mid_drive_j: got %b want %b", j, ej); else n_pass++;
    tgt_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if ({j, k, done} !== 9'b0) $display("FAIL mid_rst_outputs: got j=%b k=%b done=%b want 0", j, k, done); else n_pass++;
    n_chk++; if (txn_count !== 16'd0) $display("FAIL mid_rst_txn: got %0d want 0", txn_count); else n_pass++;
    rst_n = 1'b1;
    // the bank was clocked with the DRIVE excitation on the reset edge
    m_q = 4'b1001; m_txn = 0; m_err = 0;
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (done !== 1'b0) $display("FAIL mid_no_done: got %b want 0", done); else n_pass++;
    end
    n_chk++; if (q_fb !== m_q) $display("FAIL mid_bank_q: got %b want %b", q_fb, m_q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_txn(4'b0011, 1'b0, 1'b1, 4'b1100);
    run_txn(4'b1100, 1'b0, 1'b0, 4'b0000);
    n_chk++; if (txn_count !== 16'd2) $display("FAIL b2b_txn: got %0d want 2", txn_count); else n_pass++;
    n_chk++; if (q_fb !== 4'b1100) $display("FAIL b2b_q: got %b want 1100", q_fb); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] t, nt;
    logic       dc, hold;
    t = 4'($urandom);
    for (int n = 0; n < 24; n++) begin
      dc    = 1'($urandom);
      hold  = 1'($urandom) && (n != 23);
      nt    = 4'($urandom);
      stuck = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      run_txn(t, dc, hold, nt);
      t = nt;
    end
    stuck = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dc_one();
    test_stuck_bit();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
